mc_ctrl: RTL and testbench

Multi-cycle control FSM that drives the datapath's 3-bit ALU opcode and every datapath enable/select for a MIPS subset. It sits between the instruction register and the datapath, and is the producer side of the ALU op interface. One instruction is in flight at a time. Each instruction takes 2 to 5 cycles, sequenced by a Moore state machine.

---
 rtl/mc_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle Moore control FSM driving ALU opcode and datapath enables for a MIPS subset.
// Define MC_CTRL_SHIFT_EN to add R-type srlv/srav (ALUOp 4/5); otherwise they decode as illegal.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ExtOp,
  output logic [2:0]  ALUOp,
  output logic        retire,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
`ifdef MC_CTRL_SHIFT_EN
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_ALUWB   = 4'd3,
    S_MEMADDR = 4'd4,
    S_MEMRD   = 4'd5,
    S_MEMWB   = 4'd6,
    S_MEMWR   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
  } state_t;

  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      FN_ADDU, FN_SUBU, FN_AND, FN_OR: funct_legal = 1'b1;
`ifdef MC_CTRL_SHIFT_EN
      FN_SRLV, FN_SRAV:                funct_legal = 1'b1;
`endif
      default:                         funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_aluop(input logic [5:0] fn);
    case (fn)
      FN_ADDU: funct_aluop = 3'd0;
      FN_SUBU: funct_aluop = 3'd1;
      FN_AND:  funct_aluop = 3'd2;
      FN_OR:   funct_aluop = 3'd3;
`ifdef MC_CTRL_SHIFT_EN
      FN_SRLV: funct_aluop = 3'd4;
      FN_SRAV: funct_aluop = 3'd5;
`endif
      default: funct_aluop = 3'd0;
    endcase
  endfunction

  state_t state_q, state_d;

  logic [5:0] op_s, fn_s;
  logic       is_r_s, is_ori_s, is_lui_s, is_lw_s, is_sw_s, is_beq_s, is_j_s;
  logic       unused_instr_s;

  logic       pc_write_s, ir_write_s, reg_write_s, reg_dst_s, mem_to_reg_s, mem_write_s;
  logic [1:0] pc_src_s, alu_src_a_s, alu_src_b_s, ext_op_s;
  logic [2:0] alu_op_s;
  logic       retire_s, illegal_s;

  assign op_s           = instr[31:26];
  assign fn_s           = instr[5:0];
  assign unused_instr_s = ^instr[25:6];

  // Instruction class decode from the IR
  always_comb begin
    is_r_s   = (op_s == OP_RTYPE) && funct_legal(fn_s);
    is_ori_s = (op_s == OP_ORI);
    is_lui_s = (op_s == OP_LUI);
    is_lw_s  = (op_s == OP_LW);
    is_sw_s  = (op_s == OP_SW);
    is_beq_s = (op_s == OP_BEQ);
    is_j_s   = (op_s == OP_J);
  end

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and raw Moore outputs
  always_comb begin
    state_d      = S_FETCH;
    pc_write_s   = 1'b0;
    pc_src_s     = 2'd0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    mem_write_s  = 1'b0;
    alu_src_a_s  = 2'd0;
    alu_src_b_s  = 2'd0;
    ext_op_s     = 2'd0;
    alu_op_s     = 3'd0;
    retire_s     = 1'b0;
    illegal_s    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write_s  = 1'b1;
        pc_write_s  = 1'b1;
        pc_src_s    = 2'd0;
        alu_src_a_s = 2'd0;
        alu_src_b_s = 2'd1;
        alu_op_s    = 3'd0;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // PC + (signext(imm) << 2) precomputed so BRANCH can take it from ALUOut
        alu_src_a_s = 2'd0;
        alu_src_b_s = 2'd3;
        alu_op_s    = 3'd0;
        if (is_r_s || is_ori_s || is_lui_s) begin
          state_d = S_EXEC;
        end else if (is_lw_s || is_sw_s) begin
          state_d = S_MEMADDR;
        end else if (is_beq_s) begin
          state_d = S_BRANCH;
        end else if (is_j_s) begin
          state_d = S_JUMP;
        end else begin
          state_d   = S_FETCH;
          illegal_s = 1'b1;
          retire_s  = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r_s) begin
          alu_src_a_s = 2'd1;
          alu_src_b_s = 2'd0;
          alu_op_s    = funct_aluop(fn_s);
        end else if (is_ori_s) begin
          alu_src_a_s = 2'd1;
          alu_src_b_s = 2'd2;
          ext_op_s    = 2'd0;
          alu_op_s    = 3'd3;
        end else if (is_lui_s) begin
          alu_src_a_s = 2'd2;
          alu_src_b_s = 2'd2;
          ext_op_s    = 2'd2;
          alu_op_s    = 3'd0;
        end else begin
          alu_op_s    = 3'd0;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b0;
        reg_dst_s    = (op_s == OP_RTYPE);
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMADDR: begin
        alu_src_a_s = 2'd1;
        alu_src_b_s = 2'd2;
        ext_op_s    = 2'd1;
        alu_op_s    = 3'd0;
        if (is_lw_s) begin
          state_d = S_MEMRD;
        end else if (is_sw_s) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        reg_dst_s    = 1'b0;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        // The only Mealy-style output: taken-branch PC load follows the comparator
        alu_src_a_s = 2'd1;
        alu_src_b_s = 2'd0;
        alu_op_s    = 3'd1;
        pc_src_s    = 2'd1;
        pc_write_s  = zero;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_src_s   = 2'd2;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Hold every output low for as long as reset is asserted
  always_comb begin
    if (reset) begin
      PCWrite  = 1'b0;
      PCSrc    = 2'd0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      MemWrite = 1'b0;
      ALUSrcA  = 2'd0;
      ALUSrcB  = 2'd0;
      ExtOp    = 2'd0;
      ALUOp    = 3'd0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end else begin
      PCWrite  = pc_write_s;
      PCSrc    = pc_src_s;
      IRWrite  = ir_write_s;
      RegWrite = reg_write_s;
      RegDst   = reg_dst_s;
      MemtoReg = mem_to_reg_s;
      MemWrite = mem_write_s;
      ALUSrcA  = alu_src_a_s;
      ALUSrcB  = alu_src_b_s;
      ExtOp    = ext_op_s;
      ALUOp    = alu_op_s;
      retire   = retire_s;
      illegal  = illegal_s;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized instruction streams for mc_ctrl, checked every cycle
// against a per-instruction phase model; directed cases also pin hand-computed literals.
module tb_mc_ctrl;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       mw;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] ext;
    logic [2:0] aop;
    logic       ret;
    logic       ill;
  } ovec_t;

`ifdef MC_CTRL_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        PCWrite, IRWrite, RegWrite, RegDst, MemtoReg, MemWrite, retire, illegal;
  logic [1:0]  PCSrc, ALUSrcA, ALUSrcB, ExtOp;
  logic [2:0]  ALUOp;

  ovec_t       dut_v, exp_v;
  ovec_t       seen [0:7];
  logic        chk_en = 1'b0;
  logic [31:0] cur_ins;
  int          cur_k;
  int          total = 0;
  int          bad = 0;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUOp(ALUOp),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign dut_v = {PCWrite, PCSrc, IRWrite, RegWrite, RegDst, MemtoReg, MemWrite,
                  ALUSrcA, ALUSrcB, ExtOp, ALUOp, retire, illegal};

  function automatic bit r_legal(input logic [5:0] fn);
    return (fn == 6'h21) || (fn == 6'h23) || (fn == 6'h24) || (fn == 6'h25) ||
           (SHIFT_EN && ((fn == 6'h06) || (fn == 6'h07)));
  endfunction

  function automatic logic [2:0] r_aluop(input logic [5:0] fn);
    case (fn)
      6'h21:   return 3'd0;
      6'h23:   return 3'd1;
      6'h24:   return 3'd2;
      6'h25:   return 3'd3;
      6'h06:   return 3'd4;
      6'h07:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Cycles from FETCH to retire inclusive, straight from the instruction-class table
  function automatic int model_len(input logic [31:0] i);
    case (i[31:26])
      6'h00:               return r_legal(i[5:0]) ? 4 : 2;
      6'h0d, 6'h0f, 6'h2b: return 4;
      6'h23:               return 5;
      6'h04, 6'h02:        return 3;
      default:             return 2;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = FETCH) of instruction i
  function automatic ovec_t model(input logic [31:0] i, input int k, input logic z);
    ovec_t o;
    int    len;
    o   = '0;
    len = model_len(i);
    if (k == 0) begin
      o.irw = 1'b1; o.pcw = 1'b1; o.sb = 2'd1;
    end else if (k == 1) begin
      o.sb = 2'd3;
      if (len == 2) begin o.ill = 1'b1; o.ret = 1'b1; end
    end else begin
      o.ret = (k == len - 1);
      case (i[31:26])
        6'h00: if (k == 2) begin o.sa = 2'd1; o.aop = r_aluop(i[5:0]); end
               else begin o.rw = 1'b1; o.rd = 1'b1; end
        6'h0d: if (k == 2) begin o.sa = 2'd1; o.sb = 2'd2; o.aop = 3'd3; end
               else o.rw = 1'b1;
        6'h0f: if (k == 2) begin o.sa = 2'd2; o.sb = 2'd2; o.ext = 2'd2; end
               else o.rw = 1'b1;
        6'h23: if (k == 2) begin o.sa = 2'd1; o.sb = 2'd2; o.ext = 2'd1; end
               else if (k == 4) begin o.rw = 1'b1; o.m2r = 1'b1; end
        6'h2b: if (k == 2) begin o.sa = 2'd1; o.sb = 2'd2; o.ext = 2'd1; end
               else o.mw = 1'b1;
        6'h04: begin o.sa = 2'd1; o.aop = 3'd1; o.pcsrc = 2'd1; o.pcw = z; end
        6'h02: begin o.pcw = 1'b1; o.pcsrc = 2'd2; end
        default: o = '0;
      endcase
    end
    return o;
  endfunction

  // Single compare point against the model, every checked cycle
  always @(negedge clk) begin
    if (chk_en) begin
      total = total + 1;
      if (dut_v !== exp_v) begin
        bad = bad + 1;
        $display("FAIL model_cycle instr=%h k=%0d got=%h want=%h", cur_ins, cur_k, dut_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", nm, act, req);
    end
  endtask

  // zmode: 0/1 force zero, 2 random; nph < 0 runs the whole instruction
  task automatic run_instr(input logic [31:0] ins, input int zmode, input int nph);
    int n;
    n = (nph < 0) ? model_len(ins) : nph;
    for (int k = 0; k < n; k++) begin
      instr   = (k == 0) ? $urandom : ins;
      zero    = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      cur_ins = ins;
      cur_k   = k;
      exp_v   = model(ins, k, zero);
      chk_en  = 1'b1;
      @(negedge clk);
      #1;
      seen[k] = dut_v;
      chk_en  = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  fns [0:5];
    fns[0] = 6'h21; fns[1] = 6'h23; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h06; fns[5] = 6'h07;
    r = $urandom;
    case ($urandom_range(0, 11))
      0, 1, 2:  return {6'h00, r[25:6], fns[$urandom_range(0, 5)]};
      3:        return {6'h00, r[25:0]};
      4:        return {6'h0d, r[25:0]};
      5:        return {6'h0f, r[25:0]};
      6:        return {6'h23, r[25:0]};
      7:        return {6'h2b, r[25:0]};
      8:        return {6'h04, r[25:0]};
      9:        return {6'h02, r[25:0]};
      default:  return r;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    instr = 32'h0;
    zero  = 1'b0;
    #2;
    chk("reset_outs", int'(dut_v), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // addu right after reset release
    run_instr(32'h012A4021, 2, -1);
    chk("post_reset_irwrite", int'(seen[0].irw), 1);
    chk("post_reset_pcwrite", int'(seen[0].pcw), 1);
    chk("addu_exec_aluop", int'(seen[2].aop), 0);
    chk("addu_exec_srca", int'(seen[2].sa), 1);
    chk("addu_exec_srcb", int'(seen[2].sb), 0);
    chk("addu_exec_noretire", int'(seen[2].ret), 0);
    chk("addu_wb_regwrite", int'(seen[3].rw), 1);
    chk("addu_wb_regdst", int'(seen[3].rd), 1);
    chk("addu_wb_retire", int'(seen[3].ret), 1);

    // lw interrupted by reset during MEMRD
    run_instr(32'h8D090004, 2, 3);
    cur_k  = 3;
    exp_v  = model(32'h8D090004, 3, zero);
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("reset_mid_memrd_outs", int'(dut_v), 0);
    @(posedge clk); #1;
    chk("reset_held_outs", int'(dut_v), 0);
    reset = 1'b0;

    run_instr(32'h8D090004, 2, -1);
    chk("after_reset_irwrite", int'(seen[0].irw), 1);
    chk("after_reset_pcwrite", int'(seen[0].pcw), 1);
    chk("lw_memaddr_extop", int'(seen[2].ext), 1);
    chk("lw_memaddr_srcb", int'(seen[2].sb), 2);
    chk("lw_memrd_noretire", int'(seen[3].ret), 0);
    chk("lw_memwb_memtoreg", int'(seen[4].m2r), 1);
    chk("lw_memwb_regdst", int'(seen[4].rd), 0);
    chk("lw_memwb_retire", int'(seen[4].ret), 1);

    run_instr(32'h11090003, 1, -1);
    chk("beq_taken_pcwrite", int'(seen[2].pcw), 1);
    chk("beq_taken_pcsrc", int'(seen[2].pcsrc), 1);
    chk("beq_taken_aluop", int'(seen[2].aop), 1);
    run_instr(32'h11090003, 0, -1);
    chk("beq_nottaken_pcwrite", int'(seen[2].pcw), 0);

    run_instr(32'h3C081234, 2, -1);
    chk("lui_exec_srca", int'(seen[2].sa), 2);
    chk("lui_exec_extop", int'(seen[2].ext), 2);
    chk("lui_exec_aluop", int'(seen[2].aop), 0);
    run_instr(32'h08000010, 2, -1);
    chk("j_jump_pcsrc", int'(seen[2].pcsrc), 2);
    chk("j_jump_retire", int'(seen[2].ret), 1);

    run_instr(32'h01094007, 2, -1);
`ifdef MC_CTRL_SHIFT_EN
    chk("srav_exec_aluop", int'(seen[2].aop), 5);
    chk("srav_wb_regdst", int'(seen[3].rd), 1);
`else
    chk("srav_decode_illegal", int'(seen[1].ill), 1);
    chk("srav_decode_retire", int'(seen[1].ret), 1);
    chk("srav_no_regwrite", int'(seen[1].rw), 0);
`endif
    // next FETCH confirms the illegal/shift instruction's length
    run_instr(32'h00000025, 2, -1);

    for (int n = 0; n < 200; n++) begin
      run_instr(rand_instr(), 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
